// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the four-requester FIFO write arbiter.
package fifo_wr_arbiter_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Convert a one-hot grant vector into its requester index.
    function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick4.sv
// Combinational round-robin picker: the search starts just after the last
// winner and wraps modulo four, so the most recent winner has lowest priority.
module rr_pick4
    import fifo_wr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic [NREQ-1:0] win
);

    logic [1:0] idx;
    logic       found;

    // Scan last+1, last+2, last+3, last (2-bit wrap) and take the first set request.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Four-way round-robin arbiter feeding a single FIFO write port. A grant lasts
// up to `burst` written words; each grant is followed by one IDLE cycle.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int dw    = 8,
    parameter int burst = 4
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*dw-1:0] din,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    gnt,
    output logic               fifo_we,
    output logic [dw-1:0]      fifo_din,
    input  logic               fifo_full,
    output logic               busy
);

    localparam int            BW        = $clog2(burst) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(burst - 1);

    state_t          state;
    logic [BW-1:0]   beat;
    logic [1:0]      last;
    logic [NREQ-1:0] win;
    logic [1:0]      g;
    logic            req_g;
    logic            fire;

    rr_pick4 u_pick (
        .req  (req),
        .last (last),
        .win  (win)
    );

    // Write path is combinational from the registered grant so a word is
    // accepted in the same cycle its request is seen.
    always_comb begin
        g        = onehot_to_idx(gnt);
        req_g    = |(req & gnt);
        busy     = (state == GRANT);
        fire     = busy & req_g & ~fifo_full;
        fifo_we  = fire;
        ack      = gnt & {NREQ{fire}};
        fifo_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (busy && gnt[i]) begin
                fifo_din = din[i*dw +: dw];
            end
        end
    end

    // Grant FSM: arbitrate in IDLE, stream words in GRANT until the burst
    // limit or until the granted requester drops its request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= '0;
            beat  <= '0;
            last  <= 2'd3;
        end else if (clr) begin
            state <= IDLE;
            gnt   <= '0;
            beat  <= '0;
            last  <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= win;
                        beat  <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (fire) begin
                        beat <= beat + 1'b1;
                    end
                    if (!req_g || (fire && beat == LAST_BEAT)) begin
                        last  <= g;
                        gnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Flag a write into a full FIFO; the fire term should make this unreachable.
    always @(posedge clk) begin
        if (fifo_we && fifo_full) begin
            $display("warning: fifo_wr_arbiter wrote while fifo_full at %0t", $time);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (dw=8, burst=4).
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam logic [31:0] DIN_VAL = 32'hD3C2B1A0;

    logic          clk;
    logic          rst;
    logic          clr;
    logic [3:0]    req;
    logic [4*DW-1:0] din;
    logic [3:0]    ack;
    logic [3:0]    gnt;
    logic          fifo_we;
    logic [DW-1:0] fifo_din;
    logic          fifo_full;
    logic          busy;

    int errors = 0;
    int checks = 0;

    fifo_wr_arbiter #(.dw(DW), .burst(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .req       (req),
        .din       (din),
        .ack       (ack),
        .gnt       (gnt),
        .fifo_we   (fifo_we),
        .fifo_din  (fifo_din),
        .fifo_full (fifo_full),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic [3:0] req;
        logic       full;
        logic [3:0] gnt;
        logic       we;
        int         tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic c, input logic [3:0] r, input logic f,
                       input logic [3:0] g, input logic w, input int t);
        vec_t v;
        v.clr = c; v.req = r; v.full = f; v.gnt = g; v.we = w; v.tag = t;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] slice_of(input logic [3:0] g);
        logic [31:0] d;
        d = DIN_VAL;
        case (g)
            4'b0001: return d[7:0];
            4'b0010: return d[15:8];
            4'b0100: return d[23:16];
            4'b1000: return d[31:24];
            default: return 8'h00;
        endcase
    endfunction

    // Compare every output against an expected grant / write-enable pair.
    task automatic check_outputs(input string tag, input logic [3:0] eg, input logic ew);
        check({tag, " gnt"},  32'(gnt),      32'(eg));
        check({tag, " we"},   32'(fifo_we),  32'(ew));
        check({tag, " ack"},  32'(ack),      32'(ew ? eg : 4'b0000));
        check({tag, " busy"}, 32'(busy),     32'(eg != 4'b0000));
        check({tag, " din"},  32'(fifo_din), 32'(slice_of(eg)));
    endtask

    int ack2_count;

    initial begin
        rst = 1'b0; clr = 1'b0; req = 4'b1111; fifo_full = 1'b0; din = DIN_VAL;

        // ---------------- vector table ----------------
        // All four requesting: rotation 0,1,2,3,0 with 4 words each and a bubble.
        for (int k = 0; k < 4; k++) begin
            add(0, 4'b1111, 0, 4'b0000, 0, 1);
            for (int b = 0; b < 4; b++) add(0, 4'b1111, 0, 4'(1 << k), 1, 1);
        end
        add(0, 4'b1111, 0, 4'b0000, 0, 1);
        add(0, 4'b1111, 0, 4'b0001, 1, 1);
        add(0, 4'b0000, 0, 4'b0001, 0, 1);
        add(1, 4'b0000, 0, 4'b0000, 0, 1);
        // Requester 2 alone for 10 words: bursts 4, 4, 2.
        add(0, 4'b0100, 0, 4'b0000, 0, 2);
        for (int b = 0; b < 4; b++) add(0, 4'b0100, 0, 4'b0100, 1, 2);
        add(0, 4'b0100, 0, 4'b0000, 0, 2);
        for (int b = 0; b < 4; b++) add(0, 4'b0100, 0, 4'b0100, 1, 2);
        add(0, 4'b0100, 0, 4'b0000, 0, 2);
        for (int b = 0; b < 2; b++) add(0, 4'b0100, 0, 4'b0100, 1, 2);
        add(0, 4'b0000, 0, 4'b0100, 0, 2);
        add(0, 4'b0000, 0, 4'b0000, 0, 2);
        // Requester 1 stalled 5 cycles by fifo_full mid-burst; burst still totals 4.
        add(0, 4'b0010, 0, 4'b0000, 0, 3);
        for (int b = 0; b < 2; b++) add(0, 4'b0010, 0, 4'b0010, 1, 3);
        for (int b = 0; b < 5; b++) add(0, 4'b0010, 1, 4'b0010, 0, 3);
        for (int b = 0; b < 2; b++) add(0, 4'b0010, 0, 4'b0010, 1, 3);
        add(0, 4'b0010, 0, 4'b0000, 0, 3);
        add(0, 4'b0000, 0, 4'b0010, 0, 3);
        add(0, 4'b0000, 0, 4'b0000, 0, 3);
        // Requester 3 drops after 2 words; others ignored; next winner is 0.
        add(0, 4'b1000, 0, 4'b0000, 0, 4);
        for (int b = 0; b < 2; b++) add(0, 4'b1000, 0, 4'b1000, 1, 4);
        add(0, 4'b0111, 0, 4'b1000, 0, 4);
        add(0, 4'b0111, 0, 4'b0000, 0, 4);
        add(0, 4'b0111, 0, 4'b0001, 1, 4);
        // Stalled then request dropped: release without a write.
        add(0, 4'b0001, 1, 4'b0001, 0, 4);
        add(0, 4'b0000, 1, 4'b0001, 0, 4);
        add(0, 4'b0000, 0, 4'b0000, 0, 4);
        // IDLE arbitrates even while full.
        add(0, 4'b0010, 1, 4'b0000, 0, 5);
        add(0, 4'b0010, 1, 4'b0010, 0, 5);
        add(0, 4'b0000, 0, 4'b0010, 0, 5);
        add(0, 4'b0000, 0, 4'b0000, 0, 5);

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        check_outputs("reset", 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b1; req = 4'b0000;

        // ---------------- table loop ----------------
        ack2_count = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            clr = vecs[i].clr; req = vecs[i].req; fifo_full = vecs[i].full;
            #1;
            check_outputs($sformatf("row%0d", i), vecs[i].gnt, vecs[i].we);
            if (vecs[i].tag == 2 && ack[2]) ack2_count++;
        end
        check("req2 ack count", 32'(ack2_count), 32'd10);

        // ---------------- clr mid-burst ----------------
        @(negedge clk);
        clr = 1'b0; req = 4'b0100; fifo_full = 1'b0;
        @(negedge clk); #1;
        check_outputs("clr pre", 4'b0100, 1'b1);
        @(negedge clk);
        clr = 1'b1; req = 4'b1111;
        @(negedge clk);
        clr = 1'b0;
        #1;
        check_outputs("clr idle", 4'b0000, 1'b0);
        @(negedge clk); #1;
        check_outputs("clr regrant", 4'b0001, 1'b1);

        // ---------------- async reset during GRANT ----------------
        #1;
        rst = 1'b0;
        #1;
        check_outputs("async rst", 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        check_outputs("post rst", 4'b0001, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
